main_memory_responder: RTL and testbench

Multi-cycle main-memory model that sits on the memory side of the write-through cache controller. It responds to single-word write-through stores and to block-refill reads.
- The backing store is a 2^ADDR_WIDTH x WIDTH array named RAM, so benches can preload it with $readmemh.
- Reads return one aligned block as a serial burst of WORDS_PER_BLOCK beats after a fixed access latency.
- Writes commit one word after a fixed latency and signal completion with a strobe.

---
 rtl/main_memory_responder.sv | 134 +++++++++++++
 tb/tb_main_memory_responder.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/main_memory_responder.sv
// Multi-cycle main-memory model: block-refill reads as a serial burst after a
// fixed latency, and single-word writes that commit after a fixed latency.
module main_memory_responder #(
   parameter int unsigned ADDR_WIDTH      = 10,
   parameter int unsigned WIDTH           = 32,
   parameter int unsigned WORDS_PER_BLOCK = 4,
   parameter int unsigned READ_LATENCY    = 4,
   parameter int unsigned WRITE_LATENCY   = 2
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               mem_rd_req,
   input  logic                               mem_wr_req,
   input  logic [ADDR_WIDTH-1:0]              mem_addr,
   input  logic [WIDTH-1:0]                   mem_wr_data,
   output logic                               busy,
   output logic                               rd_valid,
   output logic [WIDTH-1:0]                   rd_data,
   output logic [$clog2(WORDS_PER_BLOCK)-1:0] rd_beat,
   output logic                               rd_last,
   output logic                               wr_done
);

   localparam int unsigned OB    = $clog2(WORDS_PER_BLOCK);
   localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
   localparam int unsigned MAX_LW = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
   localparam int unsigned MAX_C  = (MAX_LW > WORDS_PER_BLOCK) ? MAX_LW : WORDS_PER_BLOCK;
   localparam int unsigned CW     = $clog2(MAX_C + 1);

   localparam logic [CW-1:0] RD_WAIT_END = CW'((READ_LATENCY >= 2) ? READ_LATENCY - 2 : 0);
   localparam logic [CW-1:0] WR_END      = CW'(WRITE_LATENCY - 1);

   typedef enum logic [1:0] {
      IDLE,
      RD_WAIT,
      RD_BURST,
      WR_WAIT
   } state_t;

   logic [WIDTH-1:0] RAM [0:DEPTH-1];

   state_t                state, state_next;
   logic [CW-1:0]         cnt, cnt_next;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [WIDTH-1:0]      data_q;
   logic [ADDR_WIDTH-1:0] rd_addr;
   logic                  beat_fire;
   logic                  last_fire;
   logic                  commit;

   // Block base is aligned, so base+k is just the beat index in the offset bits.
   assign rd_addr = {addr_q[ADDR_WIDTH-1:OB], cnt[OB-1:0]};
   assign busy    = (state != IDLE);

   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      beat_fire  = 1'b0;
      last_fire  = 1'b0;
      commit     = 1'b0;
      unique case (state)
         IDLE: begin
            cnt_next = '0;
            if (mem_wr_req)
               state_next = WR_WAIT;
            else if (mem_rd_req)
               state_next = (READ_LATENCY == 1) ? RD_BURST : RD_WAIT;
         end
         RD_WAIT: begin
            if (cnt == RD_WAIT_END) begin
               cnt_next   = '0;
               state_next = RD_BURST;
            end else begin
               cnt_next = cnt + 1'b1;
            end
         end
         RD_BURST: begin
            beat_fire = 1'b1;
            if (cnt[OB-1:0] == '1) begin
               last_fire  = 1'b1;
               cnt_next   = '0;
               state_next = IDLE;
            end else begin
               cnt_next = cnt + 1'b1;
            end
         end
         WR_WAIT: begin
            if (cnt == WR_END) begin
               commit     = 1'b1;
               cnt_next   = '0;
               state_next = IDLE;
            end else begin
               cnt_next = cnt + 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         cnt      <= '0;
         addr_q   <= '0;
         data_q   <= '0;
         rd_valid <= 1'b0;
         rd_last  <= 1'b0;
         rd_beat  <= '0;
         rd_data  <= '0;
         wr_done  <= 1'b0;
      end else begin
         state    <= state_next;
         cnt      <= cnt_next;
         rd_valid <= beat_fire;
         rd_last  <= last_fire;
         wr_done  <= commit;
         if (state == IDLE) begin
            addr_q <= mem_addr;
            data_q <= mem_wr_data;
         end
         if (beat_fire) begin
            rd_data <= RAM[rd_addr];
            rd_beat <= cnt[OB-1:0];
         end
      end
   end

   // Contents survive reset; a reset on the commit edge suppresses the write.
   always_ff @(posedge clk) begin
      if (!reset && commit)
         RAM[addr_q] <= data_q;
   end

endmodule

// File: tb/tb_main_memory_responder.sv
// Directed self-checking bench for main_memory_responder with default parameters.
module tb_main_memory_responder;

   logic        clk = 1'b0;
   logic        reset;
   logic        mem_rd_req;
   logic        mem_wr_req;
   logic [9:0]  mem_addr;
   logic [31:0] mem_wr_data;
   logic        busy;
   logic        rd_valid;
   logic [31:0] rd_data;
   logic [1:0]  rd_beat;
   logic        rd_last;
   logic        wr_done;

   int tests = 0;
   int fails = 0;

   main_memory_responder dut (
      .clk         (clk),
      .reset       (reset),
      .mem_rd_req  (mem_rd_req),
      .mem_wr_req  (mem_wr_req),
      .mem_addr    (mem_addr),
      .mem_wr_data (mem_wr_data),
      .busy        (busy),
      .rd_valid    (rd_valid),
      .rd_data     (rd_data),
      .rd_beat     (rd_beat),
      .rd_last     (rd_last),
      .wr_done     (wr_done)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Issue a read and capture the burst; first_lat counts edges after accept.
   task automatic run_read(input logic [9:0] a, output logic [3:0][31:0] d,
                           output int nbeats, output int first_lat, output int last_beat);
      d = '0;
      nbeats = 0;
      first_lat = -1;
      last_beat = -1;
      mem_addr = a;
      mem_rd_req = 1'b1;
      step();
      mem_rd_req = 1'b0;
      for (int c = 1; c <= 20 && last_beat < 0; c++) begin
         step();
         if (rd_valid) begin
            if (first_lat < 0) first_lat = c;
            d[rd_beat] = rd_data;
            nbeats++;
            if (rd_last) last_beat = int'(rd_beat);
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      mem_rd_req = 1'b0;
      mem_wr_req = 1'b0;
      mem_addr = '0;
      mem_wr_data = '0;
      step();
      step();
      tests++;
      if ({busy, rd_valid, rd_last, wr_done, rd_beat} !== 6'b0) begin
         fails++;
         $display("FAIL reset_ctrl: got %b expected 000000", {busy, rd_valid, rd_last, wr_done, rd_beat});
      end
      tests++;
      if (rd_data !== 32'h0) begin
         fails++;
         $display("FAIL reset_data: got %h expected 00000000", rd_data);
      end
      reset = 1'b0;
      step();
   endtask

   task automatic test_read_top();
      mem_addr = 10'h3FF;
      mem_rd_req = 1'b1;
      step();
      mem_rd_req = 1'b0;
      tests++;
      if (busy !== 1'b1) begin
         fails++;
         $display("FAIL top_busy_after_accept: got %b expected 1", busy);
      end
      for (int e = 1; e <= 3; e++) begin
         step();
         tests++;
         if (rd_valid !== 1'b0) begin
            fails++;
            $display("FAIL top_early_valid edge %0d: got %b expected 0", e, rd_valid);
         end
      end
      for (int k = 0; k < 4; k++) begin
         step();
         tests++;
         if (rd_valid !== 1'b1 || rd_beat !== 2'(k) || rd_data !== 32'h3FC + 32'(k)
             || rd_last !== (k == 3)) begin
            fails++;
            $display("FAIL top_beat%0d: got v=%b beat=%0d data=%h last=%b expected v=1 beat=%0d data=%h last=%b",
                     k, rd_valid, rd_beat, rd_data, rd_last, k, 32'h3FC + 32'(k), (k == 3));
         end
      end
      tests++;
      if (busy !== 1'b0) begin
         fails++;
         $display("FAIL top_busy_at_last: got %b expected 0", busy);
      end
      step();
      tests++;
      if (rd_valid !== 1'b0 || rd_last !== 1'b0 || rd_data !== 32'h3FF) begin
         fails++;
         $display("FAIL top_after_burst: got v=%b last=%b data=%h expected v=0 last=0 data=000003ff",
                  rd_valid, rd_last, rd_data);
      end
   endtask

   task automatic test_write_then_read();
      logic [3:0][31:0] d;
      int n, lat, lb;
      mem_addr = 10'h001;
      mem_wr_data = 32'h15;
      mem_wr_req = 1'b1;
      step();
      mem_wr_req = 1'b0;
      mem_wr_data = 32'hFFFF_FFFF;
      tests++;
      if (busy !== 1'b1 || wr_done !== 1'b0) begin
         fails++;
         $display("FAIL wr_accept: got busy=%b done=%b expected busy=1 done=0", busy, wr_done);
      end
      step();
      tests++;
      if (wr_done !== 1'b0) begin
         fails++;
         $display("FAIL wr_early_done: got %b expected 0", wr_done);
      end
      step();
      tests++;
      if (wr_done !== 1'b1 || busy !== 1'b0 || dut.RAM[1] !== 32'h15) begin
         fails++;
         $display("FAIL wr_commit: got done=%b busy=%b ram=%h expected done=1 busy=0 ram=00000015",
                  wr_done, busy, dut.RAM[1]);
      end
      step();
      tests++;
      if (wr_done !== 1'b0) begin
         fails++;
         $display("FAIL wr_done_pulse: got %b expected 0", wr_done);
      end
      run_read(10'h002, d, n, lat, lb);
      tests++;
      if (d !== {32'h3, 32'h2, 32'h15, 32'h0} || n != 4 || lat != 4 || lb != 3) begin
         fails++;
         $display("FAIL rd_after_wr: got d=%h n=%0d lat=%0d last=%0d expected d=%h n=4 lat=4 last=3",
                  d, n, lat, lb, {32'h3, 32'h2, 32'h15, 32'h0});
      end
   endtask

   task automatic test_priority();
      int nv = 0;
      int nd = 0;
      mem_addr = 10'h3FF;
      mem_wr_data = 32'h5C79;
      mem_rd_req = 1'b1;
      mem_wr_req = 1'b1;
      step();
      mem_rd_req = 1'b0;
      mem_wr_req = 1'b0;
      for (int c = 0; c < 12; c++) begin
         step();
         if (rd_valid) nv++;
         if (wr_done) nd++;
      end
      tests++;
      if (nv != 0 || nd != 1 || dut.RAM[10'h3FF] !== 32'h5C79) begin
         fails++;
         $display("FAIL priority: got beats=%0d dones=%0d ram=%h expected beats=0 dones=1 ram=00005c79",
                  nv, nd, dut.RAM[10'h3FF]);
      end
   endtask

   task automatic test_busy_ignore();
      logic [3:0][31:0] d = '0;
      int n = 0;
      int nd = 0;
      int lb = -1;
      mem_addr = 10'h020;
      mem_rd_req = 1'b1;
      step();
      mem_rd_req = 1'b0;
      step();
      mem_addr = 10'h020;
      mem_wr_data = 32'hDEAD;
      mem_wr_req = 1'b1;
      step();
      step();
      mem_wr_req = 1'b0;
      for (int c = 0; c < 20 && lb < 0; c++) begin
         step();
         if (wr_done) nd++;
         if (rd_valid) begin
            d[rd_beat] = rd_data;
            n++;
            if (rd_last) lb = int'(rd_beat);
         end
      end
      for (int c = 0; c < 4; c++) begin
         step();
         if (wr_done) nd++;
      end
      tests++;
      if (d !== {32'h23, 32'h22, 32'h21, 32'h20} || n != 4 || lb != 3 || nd != 0
          || dut.RAM[10'h020] !== 32'h20) begin
         fails++;
         $display("FAIL busy_ignore: got d=%h n=%0d last=%0d dones=%0d ram=%h expected d=%h n=4 last=3 dones=0 ram=00000020",
                  d, n, lb, nd, dut.RAM[10'h020], {32'h23, 32'h22, 32'h21, 32'h20});
      end
   endtask

   task automatic test_reset_abort();
      int nv = 0;
      int nd = 0;
      bit seen = 0;
      mem_addr = 10'h040;
      mem_rd_req = 1'b1;
      step();
      mem_rd_req = 1'b0;
      for (int c = 0; c < 20 && !seen; c++) begin
         step();
         if (rd_valid && rd_beat == 2'd1) seen = 1;
      end
      tests++;
      if (!seen) begin
         fails++;
         $display("FAIL abort_beat1_seen: got 0 expected 1");
      end
      reset = 1'b1;
      step();
      reset = 1'b0;
      tests++;
      if (busy !== 1'b0 || rd_valid !== 1'b0) begin
         fails++;
         $display("FAIL abort_rd: got busy=%b v=%b expected busy=0 v=0", busy, rd_valid);
      end
      for (int c = 0; c < 6; c++) begin
         step();
         if (rd_valid) nv++;
      end
      tests++;
      if (nv != 0) begin
         fails++;
         $display("FAIL abort_rd_beats: got %0d expected 0", nv);
      end
      mem_addr = 10'h008;
      mem_wr_data = 32'hAA;
      mem_wr_req = 1'b1;
      step();
      mem_wr_req = 1'b0;
      reset = 1'b1;
      step();
      reset = 1'b0;
      for (int c = 0; c < 5; c++) begin
         step();
         if (wr_done) nd++;
      end
      tests++;
      if (nd != 0 || dut.RAM[8] !== 32'h8) begin
         fails++;
         $display("FAIL abort_wr: got dones=%0d ram=%h expected dones=0 ram=00000008", nd, dut.RAM[8]);
      end
   endtask

   task automatic test_back_to_back();
      logic [3:0][31:0] d = '0;
      int n = 0;
      int lb = -1;
      bit seen = 0;
      mem_addr = 10'h010;
      mem_rd_req = 1'b1;
      step();
      mem_rd_req = 1'b0;
      for (int c = 0; c < 20 && !seen; c++) begin
         step();
         if (rd_valid && rd_beat == 2'd2) seen = 1;
      end
      mem_addr = 10'h031;
      mem_rd_req = 1'b1;
      step();
      tests++;
      if (rd_last !== 1'b1 || rd_data !== 32'h13 || busy !== 1'b0) begin
         fails++;
         $display("FAIL b2b_last: got last=%b data=%h busy=%b expected last=1 data=00000013 busy=0",
                  rd_last, rd_data, busy);
      end
      step();
      mem_rd_req = 1'b0;
      tests++;
      if (busy !== 1'b1 || rd_valid !== 1'b0) begin
         fails++;
         $display("FAIL b2b_accept: got busy=%b v=%b expected busy=1 v=0", busy, rd_valid);
      end
      for (int c = 1; c <= 3; c++) begin
         step();
         if (rd_valid) n++;
      end
      step();
      tests++;
      if (n != 0 || rd_valid !== 1'b1 || rd_beat !== 2'd0 || rd_data !== 32'h30) begin
         fails++;
         $display("FAIL b2b_first: got early=%0d v=%b beat=%0d data=%h expected early=0 v=1 beat=0 data=00000030",
                  n, rd_valid, rd_beat, rd_data);
      end
      d[0] = rd_data;
      for (int c = 0; c < 10 && lb < 0; c++) begin
         step();
         if (rd_valid) begin
            d[rd_beat] = rd_data;
            if (rd_last) lb = int'(rd_beat);
         end
      end
      tests++;
      if (d !== {32'h33, 32'h32, 32'h31, 32'h30} || lb != 3) begin
         fails++;
         $display("FAIL b2b_burst: got d=%h last=%0d expected d=%h last=3",
                  d, lb, {32'h33, 32'h32, 32'h31, 32'h30});
      end
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) dut.RAM[i] = 32'(i);
      test_reset();
      test_read_top();
      test_write_then_read();
      test_priority();
      test_busy_ignore();
      test_reset_abort();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
